// File: rtl/riscv_instr_bus_arbiter_pkg.sv
// Shared constants for the instruction-bus arbiter slice.
package riscv_instr_bus_arbiter_pkg;

   // Instruction address width seen by the masters and the memory port.
   localparam int unsigned ARB_ADDR_W = 32;

endpackage

// File: rtl/riscv_arb_id_fifo.sv
// In-order ID FIFO: remembers which master owns each granted, unanswered fetch.
// Pointers wrap modulo DEPTH, so non-power-of-two depths are supported.
module riscv_arb_id_fifo
   import riscv_instr_bus_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_id,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_do_push;
   logic             w_do_pop;
   logic [PW-1:0]    w_wr_next;
   logic [PW-1:0]    w_rd_next;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == {CW{1'b0}});
   assign o_head    = r_mem[r_rd_ptr];

   // Overflow/underflow requests are ignored; the arbiter never issues them.
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Next pointer values with wrap at DEPTH-1.
   always_comb begin
      w_wr_next = {PW{1'b0}};
      w_rd_next = {PW{1'b0}};
      if (r_wr_ptr == PW'(DEPTH - 1)) begin
         w_wr_next = {PW{1'b0}};
      end else begin
         w_wr_next = r_wr_ptr + PW'(1);
      end
      if (r_rd_ptr == PW'(DEPTH - 1)) begin
         w_rd_next = {PW{1'b0}};
      end else begin
         w_rd_next = r_rd_ptr + PW'(1);
      end
   end

   // Storage, pointers and occupancy; push and pop may happen together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
            r_wr_ptr        <= w_wr_next;
         end
         if (w_do_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_instr_bus_arbiter_chk.sv
// Protocol checks for the instruction-bus arbiter outputs.
module riscv_instr_bus_arbiter_chk
   import riscv_instr_bus_arbiter_pkg::*;
#(
   parameter int unsigned N_MASTERS = 2
)
(
   input logic                  clk,
   input logic                  rst_n,
   input logic [N_MASTERS-1:0]  m_gnt_o,
   input logic [N_MASTERS-1:0]  m_rvalid_o,
   input logic                  mem_req_o,
   input logic                  mem_gnt_i,
   input logic [ARB_ADDR_W-1:0] mem_addr_o
);

   // At most one master is granted per cycle.
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(m_gnt_o));

   // At most one master receives a response per cycle.
   a_rvalid_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(m_rvalid_o));

   // A stalled request must stay up with an unchanged address.
   a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o)));

endmodule

// File: rtl/riscv_instr_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory req/gnt/rvalid port
// among N_MASTERS fetch requesters. A stalled request locks the selection
// so memory never sees it withdrawn; an in-order ID FIFO routes responses.
module riscv_instr_bus_arbiter
   import riscv_instr_bus_arbiter_pkg::*;
#(
   parameter int unsigned N_MASTERS       = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned RDATA_WIDTH     = 32
)
(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [N_MASTERS-1:0]                  m_req_i,
   input  logic [N_MASTERS-1:0][ARB_ADDR_W-1:0]  m_addr_i,
   output logic [N_MASTERS-1:0]                  m_gnt_o,
   output logic [N_MASTERS-1:0]                  m_rvalid_o,
   output logic [RDATA_WIDTH-1:0]                m_rdata_o,
   output logic                                  mem_req_o,
   output logic [ARB_ADDR_W-1:0]                 mem_addr_o,
   input  logic                                  mem_gnt_i,
   input  logic                                  mem_rvalid_i,
   input  logic [RDATA_WIDTH-1:0]                mem_rdata_i,
   output logic                                  busy_o,
   output logic                                  err_o
);

   localparam int unsigned IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   logic [IDW-1:0] r_rr_ptr;
   logic           r_lock;
   logic [IDW-1:0] r_lock_idx;
   logic           r_err;

   logic           w_sel_valid;
   logic [IDW-1:0] w_sel_idx;
   logic [IDW-1:0] w_rr_next;
   logic           w_mem_req;
   logic           w_grant;
   logic           w_pop;
   logic           w_fifo_full;
   logic           w_fifo_empty;
   logic [IDW-1:0] w_fifo_head;

   // Pick the locked master, else the first requester at or after rr_ptr.
   // Scanning from the farthest candidate down lets the nearest one win.
   always_comb begin
      int unsigned    v_cand;
      logic [IDW-1:0] v_idx;
      v_cand      = 0;
      v_idx       = {IDW{1'b0}};
      w_sel_valid = 1'b0;
      w_sel_idx   = {IDW{1'b0}};
      if (r_lock) begin
         w_sel_valid = 1'b1;
         w_sel_idx   = r_lock_idx;
      end else begin
         for (int k = int'(N_MASTERS) - 1; k >= 0; k--) begin
            v_cand = (int'(r_rr_ptr) + k) % N_MASTERS;
            v_idx  = IDW'(v_cand);
            if (m_req_i[v_idx]) begin
               w_sel_valid = 1'b1;
               w_sel_idx   = v_idx;
            end else begin
               w_sel_valid = w_sel_valid;
            end
         end
      end
   end

   // Full is judged on the registered count only, even if a response
   // arrives in the same cycle.
   assign w_mem_req  = w_sel_valid & ~w_fifo_full;
   assign w_grant    = w_mem_req & mem_gnt_i;
   assign w_pop      = mem_rvalid_i & ~w_fifo_empty;
   assign w_rr_next  = (w_sel_idx == IDW'(N_MASTERS - 1)) ? {IDW{1'b0}}
                                                            : w_sel_idx + IDW'(1);

   assign mem_req_o  = w_mem_req;
   assign mem_addr_o = m_addr_i[w_sel_idx];
   assign m_rdata_o  = mem_rdata_i;
   assign busy_o     = (|m_req_i) | ~w_fifo_empty;
   assign err_o      = r_err;

   // Decode grant and response routing into per-master one-hot strobes.
   always_comb begin
      m_gnt_o    = {N_MASTERS{1'b0}};
      m_rvalid_o = {N_MASTERS{1'b0}};
      for (int i = 0; i < int'(N_MASTERS); i++) begin
         if (w_grant && (w_sel_idx == IDW'(i))) begin
            m_gnt_o[i] = 1'b1;
         end else begin
            m_gnt_o[i] = 1'b0;
         end
         if (w_pop && (w_fifo_head == IDW'(i))) begin
            m_rvalid_o[i] = 1'b1;
         end else begin
            m_rvalid_o[i] = 1'b0;
         end
      end
   end

   // Lock a stalled request until granted; advance rr past each winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock     <= 1'b0;
         r_lock_idx <= {IDW{1'b0}};
         r_rr_ptr   <= {IDW{1'b0}};
      end else if (w_grant) begin
         r_lock     <= 1'b0;
         r_rr_ptr   <= w_rr_next;
      end else if (w_mem_req) begin
         r_lock     <= 1'b1;
         r_lock_idx <= w_sel_idx;
      end else begin
         r_lock     <= r_lock;
      end
   end

   // Sticky error: a response arrived with nothing outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (mem_rvalid_i && w_fifo_empty) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   riscv_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDW)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (w_grant),
      .i_push_id (w_sel_idx),
      .i_pop     (w_pop),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_head    (w_fifo_head)
   );

   riscv_instr_bus_arbiter_chk #(
      .N_MASTERS (N_MASTERS)
   ) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .m_gnt_o    (m_gnt_o),
      .m_rvalid_o (m_rvalid_o),
      .mem_req_o  (mem_req_o),
      .mem_gnt_i  (mem_gnt_i),
      .mem_addr_o (mem_addr_o)
   );

endmodule
